synth_sequencer: RTL and testbench
==================================

Name: synth_sequencer

Overview:
- Bus initiator that plays timed register writes into the synth register port (addr[7:0], data[31:0], wen, ready).
- The CPU, or a DMA path, pushes events of the form {delay, addr, data} into an internal FIFO.
- The block waits each event's delay in ticks (default 1 ms), then performs one write handshake on the synth port.
- This offloads note timing from the CPU. The block sits between the SoC bus glue and the synth block.

Parameters:
- DEPTH, 16, event FIFO entries; power of 2, ≥2.
- TICK_DIV, 48000, clk cycles per delay tick (1 ms at 48 MHz).
- TIMEOUT, 64, max cycles m_wen is held waiting for m_ready.
- HOLD, 2, cycles m_addr/m_data stay stable after m_wen falls.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- ev_valid  in  1  event push request
- ev_ready  out  1  FIFO not full; low while rst high
- ev_delay  in  16  ticks to wait after previous event's write completes
- ev_addr  in  8  synth register address
- ev_data  in  32  synth register data
- run  in  1  1 = play; 0 = pause (tick prescaler and delay frozen, no new pops)
- stop  in  1  one-cycle pulse: flush FIFO, abort pending delay
- m_addr  out  8  synth address
- m_data  out  32  synth data
- m_wen  out  1  synth write strobe
- m_ready  in  1  synth write acknowledge
- busy  out  1  state != IDLE or FIFO non-empty
- level  out  $clog2(DEPTH)+1  FIFO occupancy
- err  out  1  sticky: a write timed out
- err_clr  in  1  clears err; set has priority on the same cycle

Behaviour:
- Reset values: m_wen=0, m_addr=0, m_data=0, err=0, level=0, busy=0, FIFO empty, state IDLE, prescaler=0. ev_ready goes to 1 on the first cycle after rst falls.
- Push: occurs when ev_valid && ev_ready. ev_ready = !full.
- Simultaneous push and pop: allowed when not full; level is unchanged.
- Push in the same cycle as stop: the push is dropped.
- FSM states: IDLE, WAIT, WRITE, RELEASE. All outputs are registered.
- IDLE: if run=1 and FIFO non-empty, pop the head. Load cnt=delay, prescaler=0. Latch m_addr/m_data. Go to WAIT.
- WAIT, cnt==0: go to WRITE.
- WAIT, cnt!=0 and run=1: prescaler increments. At TICK_DIV-1, prescaler wraps to 0 and cnt decrements.
- WAIT, run=0: prescaler and cnt hold.
- Latency: m_wen first goes high exactly D*TICK_DIV+2 cycles after the pop cycle (D=ev_delay, run held 1).
- WRITE: m_wen=1 with m_addr/m_data stable. A timeout counter increments each cycle.
  - Cycle where m_ready=1 is sampled: m_wen=0 next cycle, go to RELEASE.
  - Counter reaches TIMEOUT with no m_ready: m_wen=0, err<=1, go to RELEASE. The event is discarded, not retried.
- RELEASE: m_wen=0, m_addr/m_data held for HOLD cycles (the synth consumes the address after the strobe falls), then IDLE.
- The next pop can happen the cycle after RELEASE ends. Back-to-back D=0 events have period 3+ack+HOLD cycles.
- stop in IDLE/WAIT: FIFO emptied (level=0 next cycle), state goes to IDLE, m_wen stays 0.
- stop in WRITE/RELEASE: the current handshake completes normally. The FIFO is flushed the same cycle; no further events play.
- m_ready high while in IDLE/WAIT/RELEASE: ignored.
- cnt is 16 bits, so maximum delay is 65535 ticks. No wrap handling is needed.
- Reset mid-handshake: m_wen drops on the first rst edge and the FIFO is emptied.

Optional Feature:
- Macro: SYNTH_SEQ_ALLOFF_EN.
- Defined: after a stop pulse (once any in-flight handshake completes), the block issues one write addr=8'hF4, data=0 (synth all-gates-off). It uses the normal WRITE/RELEASE path, with no delay and subject to the same timeout/err rules. busy stays high until that write completes.
- Undefined: stop only flushes the FIFO and aborts the delay; no bus write is generated.

Test Plan:
- Push {D=0, addr=8'h00, data=32'h0100_0C00}, run=1; m_ready asserts 1 cycle after m_wen → m_wen high exactly 2 cycles after pop. m_addr=00, m_data=0100_0C00 held through HOLD=2 cycles after m_wen falls. FSM back in IDLE.
- TICK_DIV=10, push D=3 then D=0 → first m_wen at pop+32; second event pops after RELEASE and its m_wen follows 2 cycles later.
- Push DEPTH+1 events with run=0 → ev_ready=0 at level=16 and the 17th push is refused. Raise run → all 16 writes emitted in push order, then level=0 and busy=0.
- Tie m_ready=0, push one event → m_wen held exactly TIMEOUT=64 cycles, then falls; err=1 and stays set. err_clr pulse → err=0.
- Push 3 events with D=100, TICK_DIV=10; pulse stop mid-WAIT of the first → no m_wen, level=0 next cycle, busy=0. With SYNTH_SEQ_ALLOFF_EN: exactly one write addr=F4, data=0.
- Assert rst during WRITE → m_wen=0 next cycle, level=0. After release, a new event plays normally.

Source files
------------

// File: rtl/synth_sequencer.sv
// Timed register-write sequencer: plays {delay, addr, data} events from a FIFO onto the synth port.
// Define SYNTH_SEQ_ALLOFF_EN to issue an all-gates-off write (addr F4, data 0) after every stop.
module synth_sequencer #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned TICK_DIV = 48000,
    parameter int unsigned TIMEOUT  = 64,
    parameter int unsigned HOLD     = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ev_valid,
    output logic                   ev_ready,
    input  logic [15:0]            ev_delay,
    input  logic [7:0]             ev_addr,
    input  logic [31:0]            ev_data,
    input  logic                   run,
    input  logic                   stop,
    output logic [7:0]             m_addr,
    output logic [31:0]            m_data,
    output logic                   m_wen,
    input  logic                   m_ready,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level,
    output logic                   err,
    input  logic                   err_clr
);
    localparam int unsigned AW        = $clog2(DEPTH);
    localparam int unsigned LW        = AW + 1;
    localparam int unsigned PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int unsigned HOLD_LAST = (HOLD > 0) ? HOLD - 1 : 0;

    typedef enum logic [1:0] {StIdle, StWait, StWrite, StRelease} state_e;

    logic [55:0]   mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [LW-1:0] level_q, level_d;
    logic          push, pop;

    state_e        state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [TW-1:0] to_q, to_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [7:0]    addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic          wen_q, wen_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;
    logic          ev_ready_q, ev_ready_d;
`ifdef SYNTH_SEQ_ALLOFF_EN
    logic          alloff_q, alloff_d;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= {ev_delay, ev_addr, ev_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || stop) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop)  rptr_q <= rptr_q + AW'(1);
        end
    end

    always_comb begin
        push    = ev_valid && ev_ready_q && !stop;
        pop     = 1'b0;
        state_d = state_q;
        cnt_d   = cnt_q;
        pre_d   = pre_q;
        to_d    = to_q;
        hold_d  = hold_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wen_d   = wen_q;
        err_d   = err_clr ? 1'b0 : err_q;
`ifdef SYNTH_SEQ_ALLOFF_EN
        alloff_d = alloff_q;
`endif

        unique case (state_q)
            StIdle: begin
`ifdef SYNTH_SEQ_ALLOFF_EN
                if (alloff_q) begin
                    state_d  = StWrite;
                    addr_d   = 8'hF4;
                    data_d   = '0;
                    wen_d    = 1'b1;
                    to_d     = '0;
                    alloff_d = 1'b0;
                end else
`endif
                if (run && level_q != '0 && !stop) begin
                    pop                     = 1'b1;
                    {cnt_d, addr_d, data_d} = mem_q[rptr_q];
                    pre_d                   = '0;
                    state_d                 = StWait;
                end
            end
            StWait: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (cnt_q == '0) begin
                    state_d = StWrite;
                    wen_d   = 1'b1;
                    to_d    = '0;
                end else if (run) begin
                    if (pre_q == PW'(TICK_DIV - 1)) begin
                        pre_d = '0;
                        cnt_d = cnt_q - 16'd1;
                    end else begin
                        pre_d = pre_q + PW'(1);
                    end
                end
            end
            StWrite: begin
                if (m_ready) begin
                    wen_d   = 1'b0;
                    hold_d  = '0;
                    state_d = StRelease;
                end else if (to_q == TW'(TIMEOUT - 1)) begin
                    // Timed-out event is dropped, not retried.
                    wen_d   = 1'b0;
                    err_d   = 1'b1;
                    hold_d  = '0;
                    state_d = StRelease;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            StRelease: begin
                if (hold_q == HW'(HOLD_LAST)) begin
                    state_d = StIdle;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

`ifdef SYNTH_SEQ_ALLOFF_EN
        if (stop) alloff_d = 1'b1;
`endif

        level_d    = stop ? '0 : level_q + LW'(push) - LW'(pop);
        ev_ready_d = (level_d != LW'(DEPTH));
        busy_d     = (state_d != StIdle) || (level_d != '0);
`ifdef SYNTH_SEQ_ALLOFF_EN
        busy_d     = busy_d || alloff_d;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            pre_q      <= '0;
            to_q       <= '0;
            hold_q     <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            wen_q      <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            level_q    <= '0;
            ev_ready_q <= 1'b0;
`ifdef SYNTH_SEQ_ALLOFF_EN
            alloff_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pre_q      <= pre_d;
            to_q       <= to_d;
            hold_q     <= hold_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wen_q      <= wen_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            level_q    <= level_d;
            ev_ready_q <= ev_ready_d;
`ifdef SYNTH_SEQ_ALLOFF_EN
            alloff_q   <= alloff_d;
`endif
        end
    end

    assign ev_ready = ev_ready_q;
    assign m_addr   = addr_q;
    assign m_data   = data_q;
    assign m_wen    = wen_q;
    assign busy     = busy_q;
    assign level    = level_q;
    assign err      = err_q;
endmodule

// File: tb/tb_synth_sequencer.sv
// Scoreboard bench for synth_sequencer: directed events queue expected writes, a monitor checks them.
module tb_synth_sequencer;
    localparam int unsigned DEPTH    = 16;
    localparam int unsigned TICK_DIV = 10;
    localparam int unsigned TIMEOUT  = 64;
    localparam int unsigned HOLD     = 2;

    logic        clk = 1'b0, rst = 1'b1;
    logic        ev_valid = 1'b0, run = 1'b0, stop = 1'b0, m_ready = 1'b0, err_clr = 1'b0;
    logic [15:0] ev_delay = '0;
    logic [7:0]  ev_addr = '0;
    logic [31:0] ev_data = '0;
    logic        ev_ready, m_wen, busy, err;
    logic [7:0]  m_addr;
    logic [31:0] m_data;
    logic [4:0]  level;

    int n_cmp = 0, n_fail = 0, cyc = 0;
    bit ack_en = 1'b1;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        int          rise;
        int          len;
    } exp_t;
    exp_t sb[$];

    synth_sequencer #(
        .DEPTH(DEPTH), .TICK_DIV(TICK_DIV), .TIMEOUT(TIMEOUT), .HOLD(HOLD)
    ) dut (
        .clk(clk), .rst(rst), .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_delay(ev_delay),
        .ev_addr(ev_addr), .ev_data(ev_data), .run(run), .stop(stop), .m_addr(m_addr),
        .m_data(m_data), .m_wen(m_wen), .m_ready(m_ready), .busy(busy), .level(level),
        .err(err), .err_clr(err_clr)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic void expect_wr(input logic [7:0] a, input logic [31:0] d,
                                      input int rise, input int len);
        exp_t e;
        e.addr = a; e.data = d; e.rise = rise; e.len = len;
        sb.push_back(e);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input logic [15:0] d, input logic [7:0] a, input logic [31:0] dt);
        ev_delay = d; ev_addr = a; ev_data = dt; ev_valid = 1'b1;
        tick();
        ev_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc, input string nm);
        int i = 0;
        while (busy && i < max_cyc) begin tick(); i++; end
        check(nm, busy, 0);
    endtask

    // Synth-side responder: acks one cycle after m_wen rises when enabled.
    initial begin
        int hi = 0;
        forever begin
            @(negedge clk);
            if (m_wen && ack_en) begin
                if (hi >= 1) m_ready = 1'b1;
                hi++;
            end else begin
                m_ready = 1'b0;
                hi = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on each strobe, checks timing, length and address hold.
    initial begin
        exp_t        cur;
        bit          prev_wen = 1'b0;
        bit          cur_ok = 1'b0;
        int          wen_len = 0, hold_left = 0;
        logic [7:0]  h_addr;
        logic [31:0] h_data;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_wen = 1'b0; cur_ok = 1'b0; hold_left = 0;
            end else begin
                if (m_wen) begin
                    if (!prev_wen) begin
                        wen_len = 1;
                        if (sb.size() == 0) begin
                            n_cmp++; n_fail++; cur_ok = 1'b0;
                            $display("FAIL unexpected write: got addr %0h data %0h expected none",
                                     m_addr, m_data);
                        end else begin
                            cur = sb.pop_front();
                            cur_ok = 1'b1;
                            check("write addr", m_addr, cur.addr);
                            check("write data", m_data, cur.data);
                            if (cur.rise >= 0) check("wen rise cycle", cyc, cur.rise);
                        end
                    end else begin
                        wen_len++;
                    end
                end else if (prev_wen) begin
                    if (cur_ok) begin
                        if (cur.len >= 0) check("wen length", wen_len, cur.len);
                        check("addr after wen fall", m_addr, cur.addr);
                        check("data after wen fall", m_data, cur.data);
                    end
                    h_addr = m_addr; h_data = m_data; hold_left = HOLD - 1;
                end else if (hold_left > 0) begin
                    check("addr hold", m_addr, h_addr);
                    check("data hold", m_data, h_data);
                    hold_left--;
                end
                prev_wen = m_wen;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int i;
        // Reset values
        repeat (3) tick();
        check("rst m_wen", m_wen, 0);
        check("rst m_addr", m_addr, 0);
        check("rst m_data", m_data, 0);
        check("rst err", err, 0);
        check("rst level", level, 0);
        check("rst busy", busy, 0);
        check("rst ev_ready", ev_ready, 0);
        rst = 1'b0;
        check("ev_ready same cycle as rst fall", ev_ready, 0);
        tick();
        check("ev_ready after rst", ev_ready, 1);

        // Single D=0 event
        push_ev(16'd0, 8'h00, 32'h0100_0C00);
        k = cyc;
        expect_wr(8'h00, 32'h0100_0C00, k + 2, 2);
        run = 1'b1;
        wait_idle(50, "t1 idle");

        // D=3 then D=0 with TICK_DIV=10
        run = 1'b0;
        push_ev(16'd3, 8'h21, 32'h1111_2222);
        push_ev(16'd0, 8'h22, 32'h3333_4444);
        k = cyc;
        expect_wr(8'h21, 32'h1111_2222, k + 32, 2);
        expect_wr(8'h22, 32'h3333_4444, k + 38, 2);
        run = 1'b1;
        wait_idle(100, "t2 idle");

        // Fill FIFO while paused; 17th push refused
        run = 1'b0;
        for (int j = 0; j < 16; j++) begin
            push_ev(16'd0, 8'(16 + j), 32'hC0DE_0000 + 32'(j));
            expect_wr(8'(16 + j), 32'hC0DE_0000 + 32'(j), -1, 2);
        end
        check("full level", level, 16);
        check("full ev_ready", ev_ready, 0);
        push_ev(16'd0, 8'hFF, 32'hDEAD_BEEF);
        check("17th push refused", level, 16);
        run = 1'b1;
        wait_idle(300, "t3 idle");
        check("t3 level", level, 0);

        // Timeout: m_ready tied low
        ack_en = 1'b0;
        push_ev(16'd0, 8'h40, 32'h0000_0040);
        expect_wr(8'h40, 32'h0000_0040, -1, TIMEOUT);
        wait_idle(150, "t4 idle");
        check("err set", err, 1);
        repeat (5) tick();
        check("err sticky", err, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err cleared", err, 0);
        ack_en = 1'b1;

        // Stop mid-WAIT
        push_ev(16'd100, 8'h30, 32'h0000_0030);
        push_ev(16'd100, 8'h31, 32'h0000_0031);
        push_ev(16'd100, 8'h32, 32'h0000_0032);
        repeat (20) tick();
`ifdef SYNTH_SEQ_ALLOFF_EN
        expect_wr(8'hF4, 32'h0, -1, 2);
`endif
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop level", level, 0);
        check("stop m_wen", m_wen, 0);
`ifdef SYNTH_SEQ_ALLOFF_EN
        wait_idle(100, "t5 alloff idle");
`else
        check("stop busy", busy, 0);
`endif
        repeat (1100) tick();
        check("t5 quiet busy", busy, 0);

        // Reset during WRITE
        ack_en = 1'b0;
        push_ev(16'd0, 8'h50, 32'h0000_0050);
        expect_wr(8'h50, 32'h0000_0050, -1, -1);
        i = 0;
        while (!m_wen && i < 20) begin tick(); i++; end
        check("t6 wen seen", m_wen, 1);
        push_ev(16'd0, 8'h51, 32'h0000_0051);
        check("t6 level before rst", level, 1);
        rst = 1'b1;
        tick();
        check("t6 rst m_wen", m_wen, 0);
        check("t6 rst level", level, 0);
        check("t6 rst ev_ready", ev_ready, 0);
        rst = 1'b0;
        tick();
        check("t6 ev_ready back", ev_ready, 1);
        check("t6 busy", busy, 0);
        ack_en = 1'b1;
        run = 1'b0;
        push_ev(16'd1, 8'h52, 32'h0000_0052);
        k = cyc;
        expect_wr(8'h52, 32'h0000_0052, k + 12, 2);
        run = 1'b1;
        wait_idle(100, "t6 idle");

        repeat (5) tick();
        check("scoreboard drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
